// File: rtl/vga_pkg.sv
// Shared VGA timing constants for 640x480@60 and the framebuffer write request.
package vga_pkg;
  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  typedef struct packed {
    logic        en;
    logic [14:0] addr;
    logic [2:0]  data;
  } fb_wr_t;

  // row*160 + col as shift-add, so no multiplier is inferred
  function automatic logic [14:0] fb_addr(input logic [6:0] row, input logic [7:0] col);
    return ({8'b0, row} << 7) + ({8'b0, row} << 5) + {7'b0, col};
  endfunction
endpackage

// File: rtl/fb_ram.sv
// Simple dual-port framebuffer RAM; synchronous read returns old data on a same-address write.
module fb_ram #(
  parameter int DEPTH = 19200,
  parameter int W     = 3,
  parameter int AW    = 15
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/vga_frame_sink.sv
// Pixel-stream sink: stores plotted pixels in a 160x120x3 framebuffer and scans it out as
// 640x480 VGA with 4x4 replication, plus a frame-start pulse for the game loop.
module vga_frame_sink
  import vga_pkg::*;
#(
  parameter int         H_RES     = 160,
  parameter int         V_RES     = 120,
  parameter int         CLK_DIV   = 2,
  parameter logic [2:0] BG_COLOUR = 3'b000,
  parameter int         H_VIS     = H_VISIBLE,
  parameter int         H_FP      = H_FRONT,
  parameter int         H_SW      = H_SYNC,
  parameter int         H_BP      = H_BACK,
  parameter int         V_VIS     = V_VISIBLE,
  parameter int         V_FP      = V_FRONT,
  parameter int         V_SW      = V_SYNC,
  parameter int         V_BP      = V_BACK
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       plot,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic       vga_clk,
  output logic       frame_start
);
  localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_VE     = HW'(H_VIS);
  localparam logic [HW-1:0] H_SS     = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] H_SE     = HW'(H_VIS + H_FP + H_SW);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_VE     = VW'(V_VIS);
  localparam logic [VW-1:0] V_SS     = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] V_SE     = VW'(V_VIS + V_FP + V_SW);
  localparam logic [7:0]    X_LIM    = 8'(H_RES);
  localparam logic [6:0]    Y_LIM    = 7'(V_RES);

  logic [DW-1:0] div;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          pix_en, h_end, v_end, visible, in_hs, in_vs;
  logic          hs_q, vs_q, blank_n_q;
  logic [2:0]    rd_colour, pix;
  logic [14:0]   raddr;
  fb_wr_t        wr;

  assign pix_en  = (div == DIV_LAST);
  assign h_end   = (hcnt == H_LAST);
  assign v_end   = (vcnt == V_LAST);
  assign visible = (hcnt < H_VE) && (vcnt < V_VE);
  assign in_hs   = (hcnt >= H_SS) && (hcnt < H_SE);
  assign in_vs   = (vcnt >= V_SS) && (vcnt < V_SE);
  assign raddr   = visible ? fb_addr(7'(vcnt >> 2), 8'(hcnt >> 2)) : '0;

  always_comb begin
    wr      = '0;
    wr.en   = plot && (x < X_LIM) && (y < Y_LIM);
    wr.addr = fb_addr(y, x);
    wr.data = colour;
  end

  fb_ram #(.DEPTH(H_RES * V_RES), .W(3), .AW(15)) u_fb (
    .clk   (clk),
    .we    (wr.en),
    .waddr (wr.addr),
    .wdata (wr.data),
    .re    (pix_en),
    .raddr (raddr),
    .rdata (rd_colour)
  );

  // syncs and blank are registered on the same tick the RAM read is issued,
  // so they line up with rd_colour one pixel later
  always_ff @(posedge clk) begin
    if (!resetn) begin
      div       <= '0;
      hcnt      <= '0;
      vcnt      <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
    end else begin
      div <= pix_en ? '0 : div + DW'(1);
      if (pix_en) begin
        hs_q      <= !in_hs;
        vs_q      <= !in_vs;
        blank_n_q <= visible;
        if (h_end) begin
          hcnt <= '0;
          vcnt <= v_end ? '0 : vcnt + VW'(1);
        end else begin
          hcnt <= hcnt + HW'(1);
        end
      end
    end
  end

  assign pix         = blank_n_q ? rd_colour : BG_COLOUR;
  assign vga_r       = {8{pix[2]}};
  assign vga_g       = {8{pix[1]}};
  assign vga_b       = {8{pix[0]}};
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;
  assign vga_sync_n  = 1'b0;
  assign vga_clk     = div[DW-1];
  assign frame_start = pix_en && h_end && v_end;
endmodule

// File: tb/tb_vga_frame_sink.sv
// Randomized bench for vga_frame_sink against a clock-count based model; vertical timing
// is shortened (16/1/2/1 lines) so two whole frames fit in a short run.
module tb_vga_frame_sink;
  localparam int CLK_DIV = 2;
  localparam int HT = 800;
  localparam int VV = 16, VFP = 1, VSY = 2, VBP = 1;
  localparam int VT = VV + VFP + VSY + VBP;

  logic       clk = 0, resetn = 0, plot = 0;
  logic [7:0] x = 0;
  logic [6:0] y = 0;
  logic [2:0] colour = 0;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk, frame_start;

  int tests = 0, fails = 0;

  vga_frame_sink #(.V_VIS(VV), .V_FP(VFP), .V_SW(VSY), .V_BP(VBP)) dut (
    .clk(clk), .resetn(resetn), .x(x), .y(y), .colour(colour), .plot(plot),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n), .vga_clk(vga_clk),
    .frame_start(frame_start)
  );

  always #10 clk = ~clk;

  // model: m_n = clk edges since reset release; displayed pixel is the previous tick's position
  logic [2:0] fb [0:19199];
  int   m_n = 0;
  bit   m_vis = 0, m_hs = 1, m_vs = 1;
  logic [2:0] m_col = 0;

  always @(posedge clk) begin
    int p, ph, pv;
    if (!resetn) begin
      m_n = 0; m_vis = 0; m_hs = 1; m_vs = 1; m_col = 0;
    end else begin
      m_n++;
      if (m_n % CLK_DIV == 0) begin
        p  = m_n / CLK_DIV - 1;
        ph = p % HT;
        pv = (p / HT) % VT;
        m_vis = (ph < 640) && (pv < VV);
        m_hs  = !(ph >= 656 && ph < 752);
        m_vs  = !(pv >= VV + VFP && pv < VV + VFP + VSY);
        m_col = m_vis ? fb[(pv / 4) * 160 + ph / 4] : 3'b000;
      end
    end
    if (plot && x < 160 && y < 120) fb[int'(y) * 160 + int'(x)] = colour;
  end

  always @(negedge clk) begin
    logic [30:0] got, exp;
    bit fs;
    fs  = (m_n % 2 == 1) && ((m_n / 2) % (HT * VT) == HT * VT - 1);
    exp = {{8{m_col[2]}}, {8{m_col[1]}}, {8{m_col[0]}}, m_hs, m_vs, m_vis, 1'b0,
           1'(m_n % 2), fs};
    got = {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk, frame_start};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL scan n=%0d got %h expected %h", m_n, got, exp);
    end
  end

  // edge timestamps after the final reset release
  bit measure = 0, prev_hs = 1, prev_vs = 1;
  int hs_fall[$], hs_rise[$], vs_fall[$], vs_rise[$], fs_at[$];
  always @(negedge clk) begin
    if (measure) begin
      if (prev_hs && !vga_hs) hs_fall.push_back(m_n);
      if (!prev_hs && vga_hs) hs_rise.push_back(m_n);
      if (prev_vs && !vga_vs) vs_fall.push_back(m_n);
      if (!prev_vs && vga_vs) vs_rise.push_back(m_n);
      if (frame_start) fs_at.push_back(m_n);
    end
    prev_hs = vga_hs;
    prev_vs = vga_vs;
  end

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_rgb(input string name, input logic [23:0] exp);
    chk(name, int'({vga_r, vga_g, vga_b}), int'(exp));
  endtask

  function automatic int qat(input int q[$], input int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  initial begin
    int guard;
    repeat (2) @(negedge clk);
    chk("reset_hs", vga_hs, 1);
    chk("reset_vs", vga_vs, 1);
    chk("reset_blank_n", vga_blank_n, 0);
    chk("reset_rgb", int'({vga_r, vga_g, vga_b}), 0);
    chk("reset_vga_clk", vga_clk, 0);

    // preload every displayable pixel while still in reset
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 160; c++) begin
        @(negedge clk);
        plot = 1; x = 8'(c); y = 7'(r); colour = 3'($urandom_range(0, 7));
      end
    @(negedge clk); x = 0; y = 0; colour = 3'b010;
    @(negedge clk); x = 5; y = 3; colour = 3'b100;
    @(negedge clk); x = 0; y = 1; colour = 3'b001;
    @(negedge clk); x = 160; y = 0; colour = 3'b111; resetn = 1;
    @(negedge clk); x = 0; y = 120; colour = 3'b111;
    @(negedge clk); plot = 0;

    guard = 0;
    while (((m_n / 2) % HT) != 300 && guard < 5000) begin
      @(negedge clk); guard++;
    end
    chk("reach_hcnt300", int'(guard < 5000), 1);
    resetn = 0;
    @(negedge clk);
    chk("midreset_hs", vga_hs, 1);
    chk("midreset_vs", vga_vs, 1);
    chk("midreset_blank_n", vga_blank_n, 0);
    resetn = 1; measure = 1;
    @(negedge clk);
    plot = 1; x = 0; y = 0; colour = 3'b110;
    @(negedge clk);
    plot = 0;
    chk_rgb("pix00_frame1_old", 24'h00FF00);

    guard = 0;
    while (m_n < 64100 && guard < 70000) begin
      @(negedge clk); guard++;
      case (m_n)
        6402:  chk_rgb("pix01_no_alias", 24'h0000FF);
        20842: chk_rgb("pix53_h20", 24'hFF0000);
        20849: chk_rgb("pix53_h23", 24'hFF0000);
        32002: chk_rgb("pix00_frame2_new", 24'hFFFF00);
        default: ;
      endcase
      plot = ($urandom_range(0, 3) == 0);
      x = 8'($urandom_range(6, 170));
      if ($urandom_range(0, 7) < 4) y = 7'($urandom_range(0, 3));
      else y = 7'($urandom_range(118, 127));
      colour = 3'($urandom_range(0, 7));
    end
    plot = 0;
    chk("run_completed", int'(m_n >= 64100), 1);

    chk("hs_fall_pos", qat(hs_fall, 0), 1314);
    chk("hs_low_width", qat(hs_rise, 0) - qat(hs_fall, 0), 192);
    chk("line_period", qat(hs_fall, 1) - qat(hs_fall, 0), 1600);
    chk("vs_low_width", qat(vs_rise, 0) - qat(vs_fall, 0), 3200);
    chk("frame_start_count", fs_at.size(), 2);
    chk("frame_start_first", qat(fs_at, 0), 31999);
    chk("frame_period", qat(fs_at, 1) - qat(fs_at, 0), 32000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
